// File: rtl/i2c_target_regfile_if.sv
// Pin-level and local-port signals of the oversampled I2C register-file target.
interface i2c_target_regfile_if #(
  parameter int unsigned PTR_W = 8
);
  logic             scl_in;
  logic             sda_in;
  logic             sda_drive_low;
  logic [PTR_W-1:0] rd_addr;
  logic [7:0]       rd_data;
  logic             wr_valid;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             busy;
  logic             gcall_valid;
  logic [7:0]       gcall_data;

  modport slave (
    input  scl_in, sda_in, rd_addr,
    output sda_drive_low, rd_data, wr_valid, wr_addr, wr_data, busy, gcall_valid, gcall_data
  );

  modport master (
    output scl_in, sda_in, rd_addr,
    input  sda_drive_low, rd_data, wr_valid, wr_addr, wr_data, busy, gcall_valid, gcall_data
  );
endinterface

// File: rtl/i2c_target_regfile.sv
// Oversampled I2C target with register file, pointer auto-increment and local read port.
// Define I2C_GCALL_EN to ACK general-call writes and report them on gcall_valid/gcall_data.
module i2c_target_regfile #(
  parameter logic [6:0]  ADDR     = 7'h42,
  parameter int unsigned NUM_REGS = 256,
  parameter int unsigned PTR_W    = $clog2(NUM_REGS),
  parameter int unsigned FILT_LEN = 3
) (
  input logic                 clk,
  input logic                 resetn,
  i2c_target_regfile_if.slave bus
);
  localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_t;

  state_t           state, state_d;
  logic [1:0]       sync1, sync2, filt, filt_q;   // bit 0 = SCL, bit 1 = SDA
  logic [CNT_W-1:0] fcnt [2];
  logic             scl_rise_c, scl_fall_c, start_c, stop_c, sda_f;
  logic [2:0]       bit_cnt, cnt_d;
  logic             byte_done, done_d;
  logic [7:0]       sh, sh_d;
  logic [PTR_W-1:0] ptr, ptr_d, ptr_inc_c;
  logic             gcall, gc_d, mack, mack_d, drive, drive_d, busy_q, busy_d;
  logic             wv_q, wv_d, mem_we_c;
  logic [PTR_W-1:0] wa_q, wa_d;
  logic [7:0]       wd_q, wd_d, rd_q;
  logic [7:0]       mem [NUM_REGS];

  // Synchroniser and run-length glitch filter for both lines
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      filt_q  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1  <= {bus.sda_in, bus.scl_in};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == CNT_W'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sda_f      = filt[1];
  assign scl_rise_c = filt[0] & ~filt_q[0];
  assign scl_fall_c = ~filt[0] & filt_q[0];
  assign start_c    = filt[0] & filt_q[0] & ~filt[1] & filt_q[1];
  assign stop_c     = filt[0] & filt_q[0] & filt[1] & ~filt_q[1];
  assign ptr_inc_c  = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + PTR_W'(1);

`ifdef I2C_GCALL_EN
  logic       gv_q, gv_d;
  logic [7:0] gd_q, gd_d;
`endif

  always_comb begin
    state_d  = state;
    cnt_d    = bit_cnt;
    done_d   = byte_done;
    sh_d     = sh;
    ptr_d    = ptr;
    gc_d     = gcall;
    mack_d   = mack;
    drive_d  = drive;
    busy_d   = busy_q;
    wv_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    mem_we_c = 1'b0;
`ifdef I2C_GCALL_EN
    gv_d     = 1'b0;
    gd_d     = gd_q;
`endif
    if (stop_c) begin
      state_d = S_IDLE;
      drive_d = 1'b0;
      busy_d  = 1'b0;
    end else if (start_c) begin
      state_d = S_ADDR;
      drive_d = 1'b0;
      cnt_d   = 3'd0;
      done_d  = 1'b0;
      gc_d    = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_REG, S_WDATA: begin
          if (scl_rise_c) begin
            sh_d   = {sh[6:0], sda_f};
            cnt_d  = bit_cnt + 3'd1;
            done_d = (bit_cnt == 3'd7);
          end else if (scl_fall_c && byte_done) begin
            done_d = 1'b0;
            if (state == S_ADDR) begin
              if (sh[7:1] == ADDR) begin
                state_d = S_ADDR_ACK;
                drive_d = 1'b1;
                busy_d  = 1'b1;
`ifdef I2C_GCALL_EN
              end else if (sh == 8'h00) begin
                state_d = S_ADDR_ACK;
                drive_d = 1'b1;
                busy_d  = 1'b1;
                gc_d    = 1'b1;
`endif
              end else begin
                state_d = S_IDLE;
              end
            end else if (state == S_REG) begin
              if (32'(sh) < NUM_REGS) begin
                state_d = S_REG_ACK;
                drive_d = 1'b1;
                ptr_d   = PTR_W'(sh);
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              state_d = S_WDATA_ACK;
              drive_d = 1'b1;
              if (!gcall) begin
                mem_we_c = 1'b1;
                wv_d     = 1'b1;
                wa_d     = ptr;
                wd_d     = sh;
                ptr_d    = ptr_inc_c;
`ifdef I2C_GCALL_EN
              end else begin
                gv_d = 1'b1;
                gd_d = sh;
`endif
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall_c) begin
            drive_d = 1'b0;
            if (gcall) begin
              state_d = S_WDATA;
            end else if (sh[0]) begin
              state_d = S_RDATA;
              sh_d    = mem[ptr];
              drive_d = ~mem[ptr][7];
            end else begin
              state_d = S_REG;
            end
          end
        end
        S_REG_ACK, S_WDATA_ACK: begin
          if (scl_fall_c) begin
            drive_d = 1'b0;
            state_d = S_WDATA;
          end
        end
        S_RDATA: begin
          if (scl_rise_c) begin
            cnt_d  = bit_cnt + 3'd1;
            done_d = (bit_cnt == 3'd7);
          end else if (scl_fall_c) begin
            if (byte_done) begin
              state_d = S_RDATA_ACK;
              drive_d = 1'b0;
              done_d  = 1'b0;
            end else begin
              sh_d    = {sh[6:0], 1'b0};
              drive_d = ~sh[6];
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise_c) begin
            mack_d = sda_f;
          end else if (scl_fall_c) begin
            if (!mack) begin
              state_d = S_RDATA;
              ptr_d   = ptr_inc_c;
              sh_d    = mem[ptr_inc_c];
              drive_d = ~mem[ptr_inc_c][7];
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
      sh        <= 8'h00;
      ptr       <= '0;
      gcall     <= 1'b0;
      mack      <= 1'b1;
      drive     <= 1'b0;
      busy_q    <= 1'b0;
      wv_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= 8'h00;
    end else begin
      state     <= state_d;
      bit_cnt   <= cnt_d;
      byte_done <= done_d;
      sh        <= sh_d;
      ptr       <= ptr_d;
      gcall     <= gc_d;
      mack      <= mack_d;
      drive     <= drive_d;
      busy_q    <= busy_d;
      wv_q      <= wv_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
    end
  end

  // Register file; the local read sees the pre-write value in the write cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) mem[i] <= 8'h00;
      rd_q <= 8'h00;
    end else begin
      if (mem_we_c) mem[ptr] <= sh;
      rd_q <= mem[bus.rd_addr];
    end
  end

`ifdef I2C_GCALL_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gv_q <= 1'b0;
      gd_q <= 8'h00;
    end else begin
      gv_q <= gv_d;
      gd_q <= gd_d;
    end
  end
  assign bus.gcall_valid = gv_q;
  assign bus.gcall_data  = gd_q;
`else
  assign bus.gcall_valid = 1'b0;
  assign bus.gcall_data  = 8'h00;
`endif

  assign bus.sda_drive_low = drive;
  assign bus.rd_data       = rd_q;
  assign bus.wr_valid      = wv_q;
  assign bus.wr_addr       = wa_q;
  assign bus.wr_data       = wd_q;
  assign bus.busy          = busy_q;
endmodule
